// File: rtl/ysyx_22040210_trap_ctrl.sv
// Trap sequencer: owns the single CSR write port, walks ECALL/MRET through
// mepc/mcause/mstatus updates, then issues one fetch redirect.
module ysyx_22040210_trap_ctrl #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_ecall_i,
  input  logic              req_mret_i,
  input  logic [XLEN-1:0]   req_pc_i,
  output logic              busy_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  input  logic              pipe_we_i,
  input  logic [CSR_AW-1:0] pipe_waddr_i,
  input  logic [XLEN-1:0]   pipe_wdata_i,
  input  logic              pipe_re_i,
  input  logic [CSR_AW-1:0] pipe_raddr_i,
  output logic [XLEN-1:0]   pipe_rdata_o,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              csr_re_o,
  output logic [CSR_AW-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]   csr_rdata_i
);

  localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] ADDR_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);
  localparam logic [XLEN-1:0]   CAUSE_ECALL  = XLEN'(11);

  typedef enum logic [2:0] {
    S_IDLE,
    S_E_MEPC,
    S_E_CAUSE,
    S_RD_STAT,
    S_E_STAT,
    S_M_STAT,
    S_E_JUMP,
    S_M_JUMP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_mstatus;
  logic            r_is_ecall;
  logic            w_accept;
  logic [XLEN-1:0] w_mstatus_ecall;
  logic [XLEN-1:0] w_mstatus_mret;

  assign w_accept = req_valid_i && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_mstatus  <= '0;
      r_is_ecall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pc       <= req_pc_i;
        r_is_ecall <= req_ecall_i;
      end
      if (r_state == S_RD_STAT) begin
        r_mstatus <= csr_rdata_i;
      end
    end
  end

  // mstatus images for trap entry and return, built from the latched copy
  always_comb begin
    w_mstatus_ecall        = r_mstatus;
    w_mstatus_ecall[7]     = r_mstatus[3];
    w_mstatus_ecall[3]     = 1'b0;
    w_mstatus_ecall[12:11] = 2'b11;

    w_mstatus_mret         = r_mstatus;
    w_mstatus_mret[3]      = r_mstatus[7];
    w_mstatus_mret[7]      = 1'b1;
    w_mstatus_mret[12:11]  = 2'b11;
  end

  always_comb begin
    w_state_nxt      = r_state;
    req_ready_o      = 1'b0;
    busy_o           = 1'b1;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    pipe_rdata_o     = '0;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    csr_re_o         = 1'b0;
    csr_raddr_o      = '0;

    case (r_state)
      S_IDLE: begin
        req_ready_o  = 1'b1;
        busy_o       = 1'b0;
        csr_we_o     = pipe_we_i;
        csr_waddr_o  = pipe_waddr_i;
        csr_wdata_o  = pipe_wdata_i;
        csr_re_o     = pipe_re_i;
        csr_raddr_o  = pipe_raddr_i;
        pipe_rdata_o = csr_rdata_i;
        // ECALL has priority; a request with neither flag is simply dropped
        if (req_valid_i) begin
          if (req_ecall_i) begin
            w_state_nxt = S_E_MEPC;
          end else if (req_mret_i) begin
            w_state_nxt = S_RD_STAT;
          end
        end
      end
      S_E_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = r_pc;
        w_state_nxt = S_E_CAUSE;
      end
      S_E_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = CAUSE_ECALL;
        w_state_nxt = S_RD_STAT;
      end
      S_RD_STAT: begin
        // read-only cycle: a concurrent write would loop through the CSR forwarding path
        csr_re_o    = 1'b1;
        csr_raddr_o = ADDR_MSTATUS;
        w_state_nxt = r_is_ecall ? S_E_STAT : S_M_STAT;
      end
      S_E_STAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = w_mstatus_ecall;
        w_state_nxt = S_E_JUMP;
      end
      S_M_STAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = w_mstatus_mret;
        w_state_nxt = S_M_JUMP;
      end
      S_E_JUMP: begin
        csr_re_o         = 1'b1;
        csr_raddr_o      = ADDR_MTVEC;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = {csr_rdata_i[XLEN-1:2], 2'b00};
        w_state_nxt      = S_IDLE;
      end
      S_M_JUMP: begin
        csr_re_o         = 1'b1;
        csr_raddr_o      = ADDR_MEPC;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_rdata_i;
        w_state_nxt      = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040210_trap_ctrl.sv
// Self-checking bench: directed trap scenarios plus randomized requests
// checked against a request-level model of the CSR side effects.
module tb_ysyx_22040210_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_ecall;
  logic        req_mret;
  logic [63:0] req_pc;
  logic        busy;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        pipe_we;
  logic [11:0] pipe_waddr;
  logic [63:0] pipe_wdata;
  logic        pipe_re;
  logic [11:0] pipe_raddr;
  logic [63:0] pipe_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        csr_re;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // CSR file stand-in
  logic [63:0] csr_mem [4096];
  always @(posedge clk) if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
  assign csr_rdata = csr_re ? csr_mem[csr_raddr] : 64'h0;

  ysyx_22040210_trap_ctrl #(.XLEN(64), .CSR_AW(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_ecall_i(req_ecall), .req_mret_i(req_mret), .req_pc_i(req_pc),
    .busy_o(busy), .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .pipe_we_i(pipe_we), .pipe_waddr_i(pipe_waddr), .pipe_wdata_i(pipe_wdata),
    .pipe_re_i(pipe_re), .pipe_raddr_i(pipe_raddr), .pipe_rdata_o(pipe_rdata),
    .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .csr_re_o(csr_re), .csr_raddr_o(csr_raddr), .csr_rdata_i(csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int I_MST = 0, I_TVEC = 1, I_EPC = 2, I_CAUSE = 3, I_SCR = 4;
  logic [11:0] addrs [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340};
  logic [63:0] ref_val [5];

  function automatic logic [63:0] ecall_mstatus(input logic [63:0] m);
    return (m & ~64'h1888) | (m[3] ? 64'h80 : 64'h0) | 64'h1800;
  endfunction

  function automatic logic [63:0] mret_mstatus(input logic [63:0] m);
    return (m & ~64'h1888) | (m[7] ? 64'h8 : 64'h0) | 64'h80 | 64'h1800;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_write(input int idx, input logic [63:0] d);
    pipe_we    = 1'b1;
    pipe_waddr = addrs[idx];
    pipe_wdata = d;
    tick();
    pipe_we    = 1'b0;
    ref_val[idx] = d;
  endtask

  task automatic pipe_read_check(input int idx, input string tag);
    pipe_re    = 1'b1;
    pipe_raddr = addrs[idx];
    #1;
    check({tag, "_re"}, {63'h0, csr_re}, 64'h1);
    check(tag, pipe_rdata, ref_val[idx]);
    pipe_re = 1'b0;
  endtask

  task automatic check_csrs(input string tag);
    check({tag, "_mstatus"}, csr_mem[addrs[I_MST]], ref_val[I_MST]);
    check({tag, "_mtvec"},   csr_mem[addrs[I_TVEC]], ref_val[I_TVEC]);
    check({tag, "_mepc"},    csr_mem[addrs[I_EPC]], ref_val[I_EPC]);
    check({tag, "_mcause"},  csr_mem[addrs[I_CAUSE]], ref_val[I_CAUSE]);
  endtask

  // Presents one request in the current (idle) cycle and follows it to the
  // cycle after the redirect; pipe noise while busy must have no effect.
  task automatic run_req(input bit ec, input bit mr, input logic [63:0] pc, input bit noisy);
    int lat;
    logic [63:0] tgt;
    tgt = 64'h0;
    lat = 0;
    check("ready_pre", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1;
    req_ecall = ec;
    req_mret  = mr;
    req_pc    = pc;
    if (ec) begin
      lat = 5;
      ref_val[I_EPC]   = pc;
      ref_val[I_CAUSE] = 64'd11;
      ref_val[I_MST]   = ecall_mstatus(ref_val[I_MST]);
      tgt = ref_val[I_TVEC] & ~64'h3;
    end else if (mr) begin
      lat = 3;
      ref_val[I_MST] = mret_mstatus(ref_val[I_MST]);
      tgt = ref_val[I_EPC];
    end
    tick();
    req_valid = 1'b0;
    req_ecall = 1'b0;
    req_mret  = 1'b0;
    req_pc    = {$urandom, $urandom};
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) tick();
      if (noisy && k <= lat) begin
        pipe_we    = 1'($urandom);
        pipe_waddr = addrs[$urandom_range(0, 4)];
        pipe_wdata = {$urandom, $urandom};
        pipe_re    = 1'b1;
        pipe_raddr = addrs[$urandom_range(0, 4)];
      end else begin
        pipe_we = 1'b0;
        pipe_re = 1'b0;
      end
      #1;
      check("busy", {63'h0, busy}, {63'h0, k <= lat});
      check("ready", {63'h0, req_ready}, {63'h0, k > lat});
      check("redir_valid", {63'h0, redirect_valid}, {63'h0, k == lat});
      if (k == lat) check("redir_pc", redirect_pc, tgt);
      if (noisy && k <= lat) check("pipe_rdata_busy", pipe_rdata, 64'h0);
    end
    pipe_we = 1'b0;
    pipe_re = 1'b0;
    check_csrs(ec ? "ecall" : (mr ? "mret" : "drop"));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_ecall = 0; req_mret = 0; req_pc = '0;
    pipe_we = 0; pipe_waddr = '0; pipe_wdata = '0; pipe_re = 0; pipe_raddr = '0;
    #3;
    check("rst_ready", {63'h0, req_ready}, 64'h1);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_redir_valid", {63'h0, redirect_valid}, 64'h0);
    check("rst_redir_pc", redirect_pc, 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // preload through the idle passthrough, including test 4
    for (int i = 0; i < 5; i++) pipe_write(i, 64'h0);
    pipe_write(I_TVEC, 64'h8000_0000);
    pipe_read_check(I_TVEC, "t4_mtvec_rd");

    // test 1
    pipe_write(I_TVEC, 64'h8000_0204);
    pipe_write(I_MST, 64'ha_0000_1808);
    run_req(1'b1, 1'b0, 64'h8000_0100, 1'b0);
    check("t1_mstatus", csr_mem[12'h300], 64'ha_0000_1880);
    check("t1_mepc", csr_mem[12'h341], 64'h8000_0100);
    check("t1_mcause", csr_mem[12'h342], 64'd11);

    // test 2
    pipe_write(I_EPC, 64'h8000_0104);
    pipe_write(I_CAUSE, 64'h5);
    run_req(1'b0, 1'b1, 64'h1234, 1'b0);
    check("t2_mstatus", csr_mem[12'h300], 64'ha_0000_1888);
    check("t2_mcause", csr_mem[12'h342], 64'h5);

    // test 3, with pipe writes while busy (second half of test 4)
    run_req(1'b1, 1'b1, 64'h8000_0300, 1'b1);

    // test 5: reset while in E_CAUSE
    pipe_write(I_CAUSE, 64'h7);
    req_valid = 1'b1; req_ecall = 1'b1; req_pc = 64'h8000_0400;
    tick();
    req_valid = 1'b0; req_ecall = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("t5_busy", {63'h0, busy}, 64'h0);
    check("t5_ready", {63'h0, req_ready}, 64'h1);
    check("t5_redir", {63'h0, redirect_valid}, 64'h0);
    tick();
    rst = 1'b0;
    ref_val[I_EPC] = 64'h8000_0400;
    for (int k = 0; k < 6; k++) begin
      check("t5_no_redir", {63'h0, redirect_valid}, 64'h0);
      tick();
    end
    check_csrs("t5");

    // test 6: MRET accepted in the cycle after the ECALL jump
    run_req(1'b1, 1'b0, 64'h8000_0500, 1'b0);
    run_req(1'b0, 1'b1, 64'h0, 1'b0);

    // randomized requests and passthrough traffic
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1: run_req(1'b1, 1'b0, {$urandom, $urandom}, 1'($urandom));
        2, 3: run_req(1'b0, 1'b1, {$urandom, $urandom}, 1'($urandom));
        4:    run_req(1'b1, 1'b1, {$urandom, $urandom}, 1'($urandom));
        5:    run_req(1'b0, 1'b0, {$urandom, $urandom}, 1'b0);
        default: begin
          int idx;
          idx = $urandom_range(0, 4);
          pipe_write(idx, {$urandom, $urandom});
          pipe_read_check($urandom_range(0, 4), "rand_pipe_rd");
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
